link_rx_deframer: RTL

Receives the byte stream from one inter-board UART link and assembles checked score frames into a 32-bit word. The word is `{board_ID, BCD points[23:0]}`. The block sits between each `uart` receiver and the external-data mux that drives `board_ID` and `char_rom_16x16`, and it replaces the raw byte concatenation there. One instance is used per link. The block also reports link liveness and counts malformed frames.

---
 rtl/link_pkg.sv | 30 +++
 rtl/link_watchdog.sv | 24 ++
 rtl/link_rx_deframer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the inter-board score link (receive deframer and
// transmit framer). The optional checksum byte is controlled by the
// LINK_RX_CHECKSUM_EN macro, which both link ends must agree on.
package link_pkg;

  localparam logic [7:0] SYNC_BYTE       = 8'hA5;
  localparam int unsigned FRAME_LEN_CHK  = 6;   // SYNC ID P2 P1 P0 CHK
  localparam int unsigned FRAME_LEN_NOCHK = 5;  // SYNC ID P2 P1 P0

`ifdef LINK_RX_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_CHK;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_NOCHK;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_ID  = 3'd1,
    GET_P2  = 3'd2,
    GET_P1  = 3'd3,
    GET_P0  = 3'd4,
    GET_CHK = 3'd5
  } link_state_t;

  // Saturating 8-bit increment for error counters
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/link_watchdog.sv
// Loadable down-counter. Reload has priority; otherwise it counts down and
// parks at zero. 'expired' is high while the count is zero.
module link_watchdog #(
  parameter int unsigned W = 8
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         reload,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Reload on request, else count down toward zero and hold there
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst)               cnt <= '0;
    else if (reload)        cnt <= load_val;
    else if (cnt != '0)     cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/link_rx_deframer.sv
// Receive deframer for one inter-board UART link. Assembles
// SYNC,ID,P2,P1,P0[,CHK] into ext_data = {ID,P2,P1,P0}, flags rejected
// frames, counts them (saturating) and tracks link liveness.
// Define LINK_RX_CHECKSUM_EN to require and verify the XOR checksum byte;
// without it frames are five bytes and are accepted on P0.
module link_rx_deframer #(
  parameter logic [7:0]  SYNC_BYTE    = link_pkg::SYNC_BYTE,
  parameter int unsigned BYTE_TIMEOUT = 75_000,
  parameter int unsigned LINK_TIMEOUT = 37_500_000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [31:0] ext_data,
  output logic        ext_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        link_up
);
  import link_pkg::*;

  localparam int unsigned GAP_W  = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned LINK_W = $clog2(LINK_TIMEOUT + 1);

  link_state_t state;
  logic [31:0] shadow;
  logic        gap_expired;
  logic        link_expired;
  logic        frame_ok;
  logic        byte_to;

`ifdef LINK_RX_CHECKSUM_EN
  logic [7:0]  chk;
  assign frame_ok = rx_valid && (state == GET_CHK) && (rx_byte == chk);
`else
  assign frame_ok = rx_valid && (state == GET_P0);
`endif

  // A byte on the expiry cycle wins over the timeout (byte_to needs !rx_valid)
  assign byte_to = (state != IDLE) && !rx_valid && gap_expired;

  // Gap timer: reloaded by every byte and held loaded while idle, so it
  // reaches zero after BYTE_TIMEOUT consecutive idle cycles inside a frame
  link_watchdog #(.W(GAP_W)) u_gap_wd (
    .pclk     (pclk),
    .rst      (rst),
    .reload   (rx_valid || (state == IDLE)),
    .load_val (GAP_W'(BYTE_TIMEOUT - 1)),
    .expired  (gap_expired)
  );

  // Liveness timer: reloaded only by good frames
  link_watchdog #(.W(LINK_W)) u_link_wd (
    .pclk     (pclk),
    .rst      (rst),
    .reload   (frame_ok),
    .load_val (LINK_W'(LINK_TIMEOUT)),
    .expired  (link_expired)
  );

  // Frame FSM with registered outputs
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shadow    <= '0;
      ext_data  <= '0;
      ext_valid <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
      link_up   <= 1'b0;
`ifdef LINK_RX_CHECKSUM_EN
      chk       <= '0;
`endif
    end else begin
      ext_valid <= 1'b0;
      frame_err <= 1'b0;

      // A good frame on the watchdog's last cycle keeps the link up
      if (frame_ok)          link_up <= 1'b1;
      else if (link_expired) link_up <= 1'b0;

      if (byte_to) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        err_cnt   <= sat_inc8(err_cnt);
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            // Non-SYNC bytes between frames are line noise, not errors
            if (rx_byte == SYNC_BYTE) state <= GET_ID;
          end
          GET_ID: begin
            shadow[31:24] <= rx_byte;
`ifdef LINK_RX_CHECKSUM_EN
            chk           <= rx_byte;
`endif
            state         <= GET_P2;
          end
          GET_P2: begin
            shadow[23:16] <= rx_byte;
`ifdef LINK_RX_CHECKSUM_EN
            chk           <= chk ^ rx_byte;
`endif
            state         <= GET_P1;
          end
          GET_P1: begin
            shadow[15:8]  <= rx_byte;
`ifdef LINK_RX_CHECKSUM_EN
            chk           <= chk ^ rx_byte;
`endif
            state         <= GET_P0;
          end
`ifdef LINK_RX_CHECKSUM_EN
          GET_P0: begin
            shadow[7:0]   <= rx_byte;
            chk           <= chk ^ rx_byte;
            state         <= GET_CHK;
          end
          GET_CHK: begin
            // Failing checksum byte is consumed, never re-read as SYNC
            state <= IDLE;
            if (frame_ok) begin
              ext_data  <= shadow;
              ext_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_cnt   <= sat_inc8(err_cnt);
            end
          end
`else
          GET_P0: begin
            shadow[7:0] <= rx_byte;
            ext_data    <= {shadow[31:8], rx_byte};
            ext_valid   <= 1'b1;
            state       <= IDLE;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
